// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
//   Sequencer for an external up/down counter (load, enable, direction,
//   registered output). It runs one sweep per accepted command: single up
//   from lo to hi, single down from hi to lo, or ping-pong between lo and hi
//   for a programmable number of reversals. A programmable dwell inserts
//   idle cycles between steps. The registered counter value (cnt_val) is
//   watched to decide when to step, turn around or finish.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   start, abort  command strobe (sampled in IDLE only) / cancel sweep
//   mode          00 single up, 01 single down, 10 ping-pong, 11 illegal
//   lo, hi        sweep bounds (inclusive)
//   dwell         extra idle cycles between steps (step period dwell+2)
//   laps          ping-pong reversals before done, 0 = until abort
//   cnt_val       registered counter output
//   cnt_load, cnt_load_val, cnt_en, cnt_up   counter controls
//   busy          high in every state except IDLE
//   done          one-cycle pulse on normal completion
//   err           one-cycle pulse on rejected command or bound violation
module counter_sweep_ctrl #(
   parameter int WIDTH   = 4,
   parameter int DWELL_W = 4,
   parameter int LAPS_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [LAPS_W-1:0]  laps,
   input  logic [WIDTH-1:0]   cnt_val,
   output logic               cnt_load,
   output logic [WIDTH-1:0]   cnt_load_val,
   output logic               cnt_en,
   output logic               cnt_up,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_PP   = 2'b10;
   localparam logic [1:0] MODE_BAD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_STEP  = 3'd3,
      S_WAIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               state_reg, state_next;

   // Command parameters captured on the accepted start cycle
   logic [1:0]           mode_reg;
   logic [WIDTH-1:0]     lo_reg;
   logic [WIDTH-1:0]     hi_reg;
   logic [DWELL_W-1:0]   dwell_reg;
   logic [LAPS_W-1:0]    laps_reg;        // remaining reversals
   logic [DWELL_W-1:0]   dwell_cnt_reg;
   logic                 cnt_up_reg;
   logic                 err_reg;

   logic                 cmd_bad;
   logic                 accept;
   logic                 reject;
   logic                 out_of_range;
   logic                 at_bound;
   logic                 is_pp;
   logic                 turn;
   logic                 last_lap;

   // Decode helpers shared by the next-state logic and the datapath
   always_comb begin
      cmd_bad      = (mode == MODE_BAD) || (lo > hi) ||
                     ((mode == MODE_PP) && (lo == hi));
      accept       = (state_reg == S_IDLE) && start && !abort && !cmd_bad;
      reject       = (state_reg == S_IDLE) && start && !abort && cmd_bad;
      out_of_range = (cnt_val < lo_reg) || (cnt_val > hi_reg);
      // End bound in the direction of travel; reaching it means no further
      // step may be issued in that direction, which is what prevents wraps.
      at_bound     = cnt_up_reg ? (cnt_val == hi_reg) : (cnt_val == lo_reg);
      is_pp        = (mode_reg == MODE_PP);
      turn         = (state_reg == S_CHECK) && !abort && !out_of_range &&
                     at_bound && is_pp;
      // laps_reg == 0 means endless; only a count of exactly one finishes
      last_lap     = (laps_reg == LAPS_W'(1));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; abort outranks everything outside IDLE
   always_comb begin
      state_next = state_reg;
      if (state_reg != S_IDLE && abort) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (accept) state_next = S_LOAD;
            end
            S_LOAD: begin
               state_next = S_CHECK;
            end
            S_CHECK: begin
               if (out_of_range) begin
                  state_next = S_IDLE;
               end else if (at_bound) begin
                  if (!is_pp || last_lap) state_next = S_DONE;
                  else                    state_next = S_STEP;
               end else begin
                  state_next = S_STEP;
               end
            end
            S_STEP: begin
               if (dwell_reg == '0) state_next = S_CHECK;
               else                 state_next = S_WAIT;
            end
            S_WAIT: begin
               // Loaded with dwell (>=1) in STEP, so WAIT lasts dwell cycles
               if (dwell_cnt_reg <= DWELL_W'(1)) state_next = S_CHECK;
            end
            S_DONE: begin
               state_next = S_IDLE;
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

   // Datapath: captured command, direction, lap and dwell counters, err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_reg      <= MODE_UP;
         lo_reg        <= '0;
         hi_reg        <= '0;
         dwell_reg     <= '0;
         laps_reg      <= '0;
         dwell_cnt_reg <= '0;
         cnt_up_reg    <= 1'b1;
         err_reg       <= 1'b0;
      end else begin
         err_reg <= reject ||
                    ((state_reg == S_CHECK) && !abort && out_of_range);

         if (accept) begin
            mode_reg   <= mode;
            lo_reg     <= lo;
            hi_reg     <= hi;
            dwell_reg  <= dwell;
            laps_reg   <= laps;
            cnt_up_reg <= (mode != MODE_DOWN);
         end

         if (turn) begin
            cnt_up_reg <= ~cnt_up_reg;
            if (laps_reg != '0) laps_reg <= laps_reg - LAPS_W'(1);
         end

         if (state_reg == S_STEP && !abort) begin
            dwell_cnt_reg <= dwell_reg;
         end else if (state_reg == S_WAIT && !abort) begin
            dwell_cnt_reg <= dwell_cnt_reg - DWELL_W'(1);
         end else if (state_reg == S_IDLE) begin
            dwell_cnt_reg <= '0;
         end
      end
   end

   // Outputs. Strobes are gated by abort so an aborted cycle never moves
   // the counter or reports completion.
   always_comb begin
      cnt_load     = (state_reg == S_LOAD) && !abort;
      cnt_load_val = '0;
      if (state_reg == S_LOAD) begin
         cnt_load_val = cnt_up_reg ? lo_reg : hi_reg;
      end
      cnt_en = (state_reg == S_STEP) && !abort;
      cnt_up = cnt_up_reg;
      busy   = (state_reg != S_IDLE);
      done   = (state_reg == S_DONE) && !abort;
      err    = err_reg;
   end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed testbench for counter_sweep_ctrl with a behavioural up/down
// counter closing the loop. Each scenario task drives stimulus, collects
// per-cycle statistics through tick/sample, and checks them inline.
module tb_counter_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] lo = '0;
   logic [3:0] hi = '0;
   logic [3:0] dwell = '0;
   logic [7:0] laps = '0;
   logic [3:0] cnt_val;
   logic       cnt_load;
   logic [3:0] cnt_load_val;
   logic       cnt_en;
   logic       cnt_up;
   logic       busy;
   logic       done;
   logic       err;

   int errors = 0;
   int checks = 0;

   // statistics gathered by sample()
   int cyc = 0;
   int en_cnt, en_up, en_down, load_cnt, done_cnt, err_cnt, busy_cnt;
   int overlap, wraps, min_gap, max_gap, last_en_cyc, load_cyc, done_cyc;
   logic [3:0] last_load_val, prev_cnt, min_cnt;

   always #5 clk = ~clk;

   counter_sweep_ctrl #(.WIDTH(4), .DWELL_W(4), .LAPS_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .lo(lo), .hi(hi), .dwell(dwell), .laps(laps), .cnt_val(cnt_val),
      .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en),
      .cnt_up(cnt_up), .busy(busy), .done(done), .err(err)
   );

   // behavioural counter driven by the controller
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           cnt_val <= '0;
      else if (cnt_load) cnt_val <= cnt_load_val;
      else if (cnt_en)   cnt_val <= cnt_up ? cnt_val + 4'd1 : cnt_val - 4'd1;
   end

   task clear_stats;
      en_cnt = 0; en_up = 0; en_down = 0; load_cnt = 0; done_cnt = 0;
      err_cnt = 0; busy_cnt = 0; overlap = 0; wraps = 0;
      min_gap = 1000; max_gap = 0; last_en_cyc = 0; load_cyc = 0;
      done_cyc = 0; last_load_val = '0; min_cnt = 4'hF; prev_cnt = cnt_val;
   endtask

   task sample;
      int gap;
      cyc++;
      if (cnt_en) begin
         if (en_cnt > 0) begin
            gap = cyc - last_en_cyc;
            if (gap < min_gap) min_gap = gap;
            if (gap > max_gap) max_gap = gap;
         end
         en_cnt++;
         if (cnt_up) en_up++; else en_down++;
         last_en_cyc = cyc;
      end
      if (cnt_load) begin
         load_cnt++;
         last_load_val = cnt_load_val;
         load_cyc = cyc;
      end
      if (cnt_load && cnt_en) overlap++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) err_cnt++;
      if (busy) begin
         busy_cnt++;
         if (cnt_val < min_cnt) min_cnt = cnt_val;
      end
      if ((prev_cnt == 4'hF && cnt_val == 4'h0) ||
          (prev_cnt == 4'h0 && cnt_val == 4'hF)) wraps++;
      prev_cnt = cnt_val;
   endtask

   // Inputs are changed 1 time unit after the rising edge; sample() sees
   // the state established by that edge.
   task tick;
      @(posedge clk);
      #1;
      sample();
   endtask

   // One-cycle start strobe; afterwards the command inputs are scrambled to
   // show that only the start-cycle values matter.
   task pulse_start(input logic [1:0] m, input logic [3:0] l, input logic [3:0] h,
                    input logic [3:0] d, input logic [7:0] n);
      mode = m; lo = l; hi = h; dwell = d; laps = n; start = 1'b1;
      tick();
      start = 1'b0; mode = 2'b11; lo = 4'hF; hi = 4'h0; dwell = 4'h0; laps = 8'h0;
   endtask

   task run_to_idle(input int max_cyc, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         tick();
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task test_reset;
      rst = 1'b1;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (cnt_up !== 1'b1) begin errors++; $display("FAIL reset_cnt_up got=%b exp=1", cnt_up); end
      checks++; if ({cnt_load, cnt_en, done, err} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {cnt_load, cnt_en, done, err}); end
      checks++; if (cnt_load_val !== 4'h0) begin errors++; $display("FAIL reset_load_val got=%0d exp=0", cnt_load_val); end
      rst = 1'b0;
      tick();
      $display("test_reset: busy=%b cnt_up=%b", busy, cnt_up);
   endtask

   task test_single_up;
      bit to;
      clear_stats();
      pulse_start(2'b00, 4'd3, 4'd7, 4'd0, 8'd0);
      run_to_idle(100, to);
      checks++; if (to) begin errors++; $display("FAIL up_timeout got=busy exp=idle"); end
      checks++; if (load_cnt != 1 || last_load_val !== 4'd3) begin errors++; $display("FAIL up_load got=%0d/%0d exp=1/3", load_cnt, last_load_val); end
      checks++; if (en_cnt != 4 || en_down != 0) begin errors++; $display("FAIL up_steps got=%0d(down %0d) exp=4(down 0)", en_cnt, en_down); end
      checks++; if (min_gap != 2 || max_gap != 2) begin errors++; $display("FAIL up_gap got=%0d..%0d exp=2..2", min_gap, max_gap); end
      checks++; if (done_cnt != 1 || done_cyc - last_en_cyc != 2) begin errors++; $display("FAIL up_done got=%0d@+%0d exp=1@+2", done_cnt, done_cyc - last_en_cyc); end
      checks++; if (cnt_val !== 4'd7 || busy !== 1'b0) begin errors++; $display("FAIL up_end got=%0d/%b exp=7/0", cnt_val, busy); end
      checks++; if (overlap != 0 || err_cnt != 0) begin errors++; $display("FAIL up_overlap_err got=%0d/%0d exp=0/0", overlap, err_cnt); end
      $display("test_single_up: steps=%0d cnt=%0d done=%0d", en_cnt, cnt_val, done_cnt);
   endtask

   task test_single_down;
      bit to;
      clear_stats();
      pulse_start(2'b01, 4'd2, 4'd9, 4'd2, 8'd0);
      checks++; if (cnt_up !== 1'b0 || cnt_load_val !== 4'd9) begin errors++; $display("FAIL down_load got=%b/%0d exp=0/9", cnt_up, cnt_load_val); end
      run_to_idle(100, to);
      checks++; if (to) begin errors++; $display("FAIL down_timeout got=busy exp=idle"); end
      checks++; if (en_cnt != 7 || en_up != 0) begin errors++; $display("FAIL down_steps got=%0d(up %0d) exp=7(up 0)", en_cnt, en_up); end
      checks++; if (min_gap != 4 || max_gap != 4) begin errors++; $display("FAIL down_gap got=%0d..%0d exp=4..4", min_gap, max_gap); end
      checks++; if (cnt_val !== 4'd2 || min_cnt < 4'd2 || done_cnt != 1) begin errors++; $display("FAIL down_end got=%0d min=%0d done=%0d exp=2 min=2 done=1", cnt_val, min_cnt, done_cnt); end
      $display("test_single_down: steps=%0d cnt=%0d done=%0d", en_cnt, cnt_val, done_cnt);
   endtask

   task test_ping_pong;
      bit to;
      clear_stats();
      pulse_start(2'b10, 4'd0, 4'd15, 4'd0, 8'd2);
      run_to_idle(200, to);
      checks++; if (to) begin errors++; $display("FAIL pp_timeout got=busy exp=idle"); end
      checks++; if (en_cnt != 30 || en_up != 15 || en_down != 15) begin errors++; $display("FAIL pp_steps got=%0d up=%0d down=%0d exp=30 up=15 down=15", en_cnt, en_up, en_down); end
      checks++; if (wraps != 0) begin errors++; $display("FAIL pp_wrap got=%0d exp=0", wraps); end
      checks++; if (done_cnt != 1 || cnt_val !== 4'd0) begin errors++; $display("FAIL pp_end got=done %0d cnt %0d exp=done 1 cnt 0", done_cnt, cnt_val); end
      $display("test_ping_pong: steps=%0d up=%0d down=%0d wraps=%0d", en_cnt, en_up, en_down, wraps);
   endtask

   task test_rejects;
      logic [1:0] rm [3];
      logic [3:0] rl [3];
      logic [3:0] rh [3];
      rm = '{2'b11, 2'b00, 2'b10};
      rl = '{4'd1,  4'd8,  4'd5};
      rh = '{4'd9,  4'd3,  4'd5};
      for (int k = 0; k < 3; k++) begin
         clear_stats();
         pulse_start(rm[k], rl[k], rh[k], 4'd0, 8'd1);
         tick(); tick(); tick();
         checks++; if (err_cnt != 1) begin errors++; $display("FAIL reject%0d_err got=%0d exp=1", k, err_cnt); end
         checks++; if (busy_cnt != 0 || load_cnt != 0) begin errors++; $display("FAIL reject%0d_idle got=busy %0d load %0d exp=0 0", k, busy_cnt, load_cnt); end
         $display("test_rejects[%0d]: err pulses=%0d busy cycles=%0d", k, err_cnt, busy_cnt);
      end
   endtask

   task test_abort;
      bit found;
      clear_stats();
      found = 1'b0;
      pulse_start(2'b00, 4'd3, 4'd12, 4'd3, 8'd0);
      for (int i = 0; i < 60; i++) begin
         tick();
         if (cnt_val == 4'd5) begin found = 1'b1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL abort_reach5 got=%0d exp=5", cnt_val); end
      abort = 1'b1;          // first WAIT cycle after the step to 5
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b exp=0", busy); end
      tick(); tick(); tick(); tick();
      checks++; if (cnt_val !== 4'd5 || done_cnt != 0 || err_cnt != 0) begin errors++; $display("FAIL abort_hold got=cnt %0d done %0d err %0d exp=5 0 0", cnt_val, done_cnt, err_cnt); end
      $display("test_abort: cnt=%0d busy=%b", cnt_val, busy);
   endtask

   task test_start_while_busy;
      bit to;
      clear_stats();
      pulse_start(2'b00, 4'd3, 4'd5, 4'd1, 8'd0);
      tick(); tick();
      pulse_start(2'b11, 4'd0, 4'd1, 4'd0, 8'd0);
      run_to_idle(60, to);
      checks++; if (to || load_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL busy_start got=to %0d load %0d err %0d exp=0 1 0", to, load_cnt, err_cnt); end
      checks++; if (done_cnt != 1 || cnt_val !== 4'd5) begin errors++; $display("FAIL busy_start_end got=done %0d cnt %0d exp=1 5", done_cnt, cnt_val); end
      $display("test_start_while_busy: loads=%0d cnt=%0d", load_cnt, cnt_val);
   endtask

   task test_start_abort_idle;
      clear_stats();
      abort = 1'b1;
      pulse_start(2'b00, 4'd1, 4'd4, 4'd0, 8'd0);
      abort = 1'b0;
      tick(); tick();
      checks++; if (busy_cnt != 0 || load_cnt != 0 || err_cnt != 0) begin errors++; $display("FAIL start_abort got=busy %0d load %0d err %0d exp=0 0 0", busy_cnt, load_cnt, err_cnt); end
      $display("test_start_abort_idle: busy cycles=%0d", busy_cnt);
   endtask

   task test_reset_mid_step;
      bit found;
      clear_stats();
      found = 1'b0;
      pulse_start(2'b01, 4'd0, 4'd15, 4'd3, 8'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cnt_en) begin found = 1'b1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL rst_reach_step got=no step exp=step"); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({busy, cnt_en, cnt_load, done, err} !== 5'b0 || cnt_up !== 1'b1 || cnt_load_val !== 4'd0) begin
         errors++; $display("FAIL rst_async got=%b up=%b val=%0d exp=00000 up=1 val=0", {busy, cnt_en, cnt_load, done, err}, cnt_up, cnt_load_val);
      end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0 || done_cnt != 0) begin errors++; $display("FAIL rst_after got=busy %b done %0d exp=0 0", busy, done_cnt); end
      $display("test_reset_mid_step: busy=%b cnt_up=%b", busy, cnt_up);
   endtask

   task test_equal_bounds;
      bit to;
      clear_stats();
      pulse_start(2'b00, 4'd6, 4'd6, 4'd0, 8'd0);
      run_to_idle(20, to);
      checks++; if (to || load_cnt != 1 || en_cnt != 0) begin errors++; $display("FAIL eq_steps got=to %0d load %0d en %0d exp=0 1 0", to, load_cnt, en_cnt); end
      checks++; if (done_cnt != 1 || done_cyc - load_cyc != 2 || cnt_val !== 4'd6) begin errors++; $display("FAIL eq_done got=done %0d @+%0d cnt %0d exp=1 @+2 6", done_cnt, done_cyc - load_cyc, cnt_val); end
      $display("test_equal_bounds: steps=%0d cnt=%0d", en_cnt, cnt_val);
   endtask

   initial begin
      clear_stats();
      test_reset();
      test_single_up();
      test_single_down();
      test_ping_pong();
      test_rejects();
      test_abort();
      test_start_while_busy();
      test_start_abort_idle();
      test_reset_mid_step();
      test_equal_bounds();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the team's up/down counter (clock enable, load, direction select `sel`, registered output).
- Runs commanded sweeps: single up, single down, or ping-pong between programmable lo/hi bounds, with a programmable dwell between steps.
- Sits between a command source (start/abort) and the counter.
- Drives the counter's load, enable and direction; watches its registered output to decide when to step, turn or finish.

Parameters:
- WIDTH, 4, counter width; lo, hi, cnt_val and cnt_load_val are WIDTH bits.
- DWELL_W, 4, width of the dwell field.
- LAPS_W, 8, width of the ping-pong reversal count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- abort  in  1  cancels any active sweep.
- mode  in  2  00 single up, 01 single down, 10 ping-pong, 11 illegal.
- lo  in  WIDTH  lower bound.
- hi  in  WIDTH  upper bound.
- dwell  in  DWELL_W  extra idle cycles between steps.
- laps  in  LAPS_W  ping-pong reversals before done; 0 = run until abort.
- cnt_val  in  WIDTH  registered counter output.
- cnt_load  out  1  counter synchronous load strobe.
- cnt_load_val  out  WIDTH  value to load.
- cnt_en  out  1  counter step enable, one cycle per step.
- cnt_up  out  1  direction to counter `sel`: 1 up, 0 down.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on rejected command or bound violation.

Behaviour:
- Reset (async, rst=1) forces: state IDLE, cnt_load=0, cnt_load_val=0, cnt_en=0, cnt_up=1, busy=0, done=0, err=0. Internal dwell and lap counters also clear. Asserting rst mid-sweep aborts immediately; no done pulse.
- States: IDLE, LOAD, CHECK, STEP, WAIT, DONE.
- IDLE, start=1:
  - Illegal command (mode=11, lo>hi, or ping-pong with lo==hi): err=1 for the next cycle, stay IDLE.
  - Otherwise: latch mode/lo/hi/dwell/laps, go to LOAD. Inputs may change after the start cycle without effect.
- LOAD (1 cycle):
  - cnt_load=1.
  - cnt_load_val = lo for up/ping-pong, hi for down.
  - cnt_up = 1 for up/ping-pong, 0 for down.
  - Next state CHECK.
- CHECK: cnt_val reflects the previous load or step.
  - cnt_val outside [lo,hi]: err pulse, go IDLE; no done.
  - Single mode, cnt_val equals end bound (hi up, lo down): go DONE.
  - Ping-pong, cnt_val equals the bound in the current direction: toggle cnt_up; decrement remaining laps if laps≠0. If the remaining count reaches 0, go DONE; otherwise go STEP in the new direction.
  - Otherwise: go STEP.
- STEP (1 cycle): cnt_en=1.
  - dwell=0: go to CHECK.
  - dwell>0: load the dwell counter and go WAIT.
- WAIT: decrement each cycle; on the cycle the counter reaches 0, go CHECK.
- Step period is dwell+2 cycles.
- DONE (1 cycle): done=1, then IDLE. busy drops the cycle after done.
- Wrap-around: the controller never issues cnt_en when cnt_val is at the bound in the current direction, so the counter never wraps.
- abort=1 in any non-IDLE state: go IDLE next cycle. cnt_en/cnt_load deassert; no done, no err; the counter holds its value. abort in IDLE is a no-op.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins, start is ignored.
- cnt_up holds its last value in IDLE.
- cnt_load and cnt_en are never high in the same cycle.

Test Plan:
- The bench instantiates a behavioural WIDTH-bit up/down counter with load and enable, fed by this block's outputs.
- Single up, lo=3 hi=7 dwell=0 -> cnt_load with cnt_load_val=3; 4 cnt_en pulses spaced 2 cycles apart; cnt_up=1 throughout; done 1 cycle after CHECK sees 7; busy low after.
- Single down, lo=2 hi=9 dwell=2 -> load 9, cnt_up=0; 7 cnt_en pulses every 4 cycles; done at cnt_val=2; no pulse below 2.
- Ping-pong, lo=0 hi=15 laps=2 -> 0→15 (cnt_up=1→0 at 15) then 15→0; done after 30 cnt_en pulses; counter never shows a 15→0 or 0→15 wrap.
- Rejects: mode=11; lo=8 hi=3; ping-pong lo=hi=5 -> each gives a single err pulse; busy stays 0; no cnt_load.
- Control events: abort in WAIT of an up sweep at cnt_val=5 -> IDLE next cycle, counter holds 5, no done. start during busy is ignored. start+abort together in IDLE -> stays IDLE. rst pulsed mid-STEP -> all outputs at reset values immediately, without waiting for a clock edge.
- Single up, lo=hi=6 -> LOAD, CHECK, then done; zero cnt_en pulses.
